// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scanner: hex glyph table,
// blank pattern, digit count and the value/dp/blank buffer record.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DP_BIT     = 7;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Bits {g,f,e,d,c,b,a}; bit 7 is left clear and filled with the dp later.
    localparam logic [7:0] SEG_HEX [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F,
        8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C,
        8'h39, 8'h5E, 8'h79, 8'h71
    };

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
    } disp_buf_t;

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] idx);
        digit_onehot      = '0;
        digit_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational glyph encoder: one hex nibble plus dp/blank to the 8-bit
// segment pattern {dp,g,f,e,d,c,b,a}, active-high.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o         = SEG_HEX[nibble_i];
        seg_o[DP_BIT] = dp_i;
        // Blank darkens the whole digit, decimal point included.
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment driver with a double-buffered display
// image that only changes at frame boundaries.
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          SEG_INVERT  = 1'b0
) (
    input  logic        in_clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    input  logic        load,
    output logic [7:0]  Seven_Seg,
    output logic [3:0]  digit,
    output logic        frame_done
);

    localparam int unsigned     PW        = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ONE = PW'(1);
    localparam logic [7:0]      SEG_XOR   = SEG_INVERT ? 8'hFF : 8'h00;

    logic [PW-1:0]          presc_q, presc_d;
    logic [1:0]             idx_q, idx_d;
    disp_buf_t              pend_q, pend_d;
    disp_buf_t              disp_q, disp_d;
    disp_buf_t              in_buf;
    logic [7:0]             seg_q, seg_d;
    logic [NUM_DIGITS-1:0]  digit_q, digit_d;
    // [0]: boundary seen last cycle, [1]: aligned with digit 0 reappearing.
    logic [1:0]             bnd_pipe_q, bnd_pipe_d;

    logic                   tick;
    logic                   frame_bnd;
    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic                   cur_blank;
    logic [7:0]             enc_seg;

    assign in_buf = '{value: value, dp: dp, blank: blank};

    always_comb begin
        tick      = (presc_q == PRESC_MAX);
        frame_bnd = tick && (idx_q == 2'd3);
        presc_d   = tick ? '0 : presc_q + PRESC_ONE;
        idx_d     = tick ? idx_q + 2'd1 : idx_q;
    end

    // Loading on the boundary cycle bypasses pending so it shows next frame.
    always_comb begin
        pend_d = load ? in_buf : pend_q;
        disp_d = disp_q;
        if (frame_bnd) begin
            disp_d = load ? in_buf : pend_q;
        end
    end

    always_comb begin
        cur_nib   = disp_q.value[{idx_q, 2'b00} +: 4];
        cur_dp    = disp_q.dp[idx_q];
        cur_blank = disp_q.blank[idx_q];
    end

    hex_to_seg7 u_enc (
        .nibble_i (cur_nib),
        .dp_i     (cur_dp),
        .blank_i  (cur_blank),
        .seg_o    (enc_seg)
    );

    always_comb begin
        digit_d    = digit_onehot(idx_q);
        seg_d      = enc_seg ^ SEG_XOR;
        bnd_pipe_d = {bnd_pipe_q[0], frame_bnd};
    end

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            disp_q <= '0;
        end else begin
            pend_q <= pend_d;
            disp_q <= disp_d;
        end
    end

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            digit_q    <= 4'b0001;
            seg_q      <= SEG_BLANK ^ SEG_XOR;
            bnd_pipe_q <= 2'b00;
        end else begin
            digit_q    <= digit_d;
            seg_q      <= seg_d;
            bnd_pipe_q <= bnd_pipe_d;
        end
    end

    assign Seven_Seg  = seg_q;
    assign digit      = digit_q;
    assign frame_done = bnd_pipe_q[1];

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner at REFRESH_DIV=4, with a normal and an
// inverted-segment instance sharing the same stimulus.
module tb_seven_seg_scanner;

    logic        in_clk = 1'b0;
    logic        rst    = 1'b0;
    logic [15:0] value  = '0;
    logic [3:0]  dp     = '0;
    logic [3:0]  blank  = '0;
    logic        load   = 1'b0;
    logic [7:0]  seg, seg_inv;
    logic [3:0]  digit, digit_inv;
    logic        fd, fd_inv;

    int checks   = 0;
    int failures = 0;
    int n        = 0;   // rising edges since the last reset release

    always #5 in_clk = ~in_clk;

    seven_seg_scanner #(.REFRESH_DIV(4), .SEG_INVERT(1'b0)) dut (
        .in_clk(in_clk), .rst(rst), .value(value), .dp(dp), .blank(blank),
        .load(load), .Seven_Seg(seg), .digit(digit), .frame_done(fd)
    );

    seven_seg_scanner #(.REFRESH_DIV(4), .SEG_INVERT(1'b1)) dut_inv (
        .in_clk(in_clk), .rst(rst), .value(value), .dp(dp), .blank(blank),
        .load(load), .Seven_Seg(seg_inv), .digit(digit_inv), .frame_done(fd_inv)
    );

    task automatic step();
        @(posedge in_clk);
        #1;
        n++;
    endtask

    task automatic step_to(input int t);
        while (n < t) step();
    endtask

    function automatic logic [3:0] exp_digit(input int e);
        logic [3:0] one;
        one = 4'b0001;
        return one << (((e - 1) / 4) % 4);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (digit !== 4'b0001) begin failures++; $display("FAIL reset_digit got=%b exp=0001", digit); end
        checks++;
        if (seg !== 8'h00) begin failures++; $display("FAIL reset_seg got=%h exp=00", seg); end
        checks++;
        if (fd !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", fd); end
        checks++;
        if (seg_inv !== 8'hFF) begin failures++; $display("FAIL reset_seg_inv got=%h exp=FF", seg_inv); end
        rst = 1'b1;
        n = 0;
    endtask

    // Two full frames of zeros: digit stepping and frame_done cadence.
    task automatic test_scan();
        while (n < 32) begin
            step();
            checks++;
            if (digit !== exp_digit(n))
                begin failures++; $display("FAIL scan_digit edge=%0d got=%b exp=%b", n, digit, exp_digit(n)); end
            checks++;
            if (fd !== (n == 17))
                begin failures++; $display("FAIL scan_frame_done edge=%0d got=%b exp=%b", n, fd, (n == 17)); end
            checks++;
            if (seg !== 8'h3F)
                begin failures++; $display("FAIL scan_seg edge=%0d got=%h exp=3F", n, seg); end
        end
    endtask

    task automatic test_deferred_load();
        logic [7:0] exp [4];
        exp = '{8'h66, 8'h4F, 8'h5B, 8'h06};
        value = 16'h5555; load = 1'b1;
        step();                                   // edge 33 captures 5555
        load = 1'b0;
        step();
        value = 16'h1234; load = 1'b1;
        step();                                   // edge 35 captures 1234, last wins
        load = 1'b0; value = 16'h0000;
        while (n < 48) begin
            step();
            checks++;
            if (seg !== 8'h3F)
                begin failures++; $display("FAIL deferred_old_frame edge=%0d got=%h exp=3F", n, seg); end
        end
        for (int i = 0; i < 4; i++) begin
            step_to(49 + 4 * i);
            checks++;
            if (seg !== exp[i] || digit !== exp_digit(n))
                begin failures++; $display("FAIL deferred_new_frame d%0d got=%h/%b exp=%h/%b", i, seg, digit, exp[i], exp_digit(n)); end
        end
    endtask

    task automatic test_load_at_boundary();
        logic [7:0] exp [4];
        exp = '{8'h5E, 8'h39, 8'h7C, 8'h77};
        step_to(79);
        value = 16'hABCD; load = 1'b1;
        step();                                   // edge 80 is the frame boundary
        load = 1'b0; value = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            step_to(81 + 4 * i);
            checks++;
            if (seg !== exp[i] || digit !== exp_digit(n))
                begin failures++; $display("FAIL bypass_frame d%0d got=%h/%b exp=%h/%b", i, seg, digit, exp[i], exp_digit(n)); end
            if (i == 0) begin
                checks++;
                if (fd !== 1'b1) begin failures++; $display("FAIL bypass_frame_done got=%b exp=1", fd); end
            end
        end
        step_to(97);
        checks++;
        if (seg !== 8'h5E) begin failures++; $display("FAIL bypass_pending_kept got=%h exp=5E", seg); end
    endtask

    task automatic test_dp_blank();
        logic [7:0] exp [4];
        logic [7:0] exp_i [4];
        exp   = '{8'hFF, 8'h00, 8'hFF, 8'h7F};
        exp_i = '{8'h00, 8'hFF, 8'h00, 8'h80};
        step_to(100);
        value = 16'h8888; dp = 4'b0101; blank = 4'b0010; load = 1'b1;
        step();
        load = 1'b0; value = '0; dp = '0; blank = '0;
        for (int i = 0; i < 4; i++) begin
            step_to(113 + 4 * i);
            checks++;
            if (seg !== exp[i])
                begin failures++; $display("FAIL dp_blank d%0d got=%h exp=%h", i, seg, exp[i]); end
            checks++;
            if (seg_inv !== exp_i[i])
                begin failures++; $display("FAIL dp_blank_inv d%0d got=%h exp=%h", i, seg_inv, exp_i[i]); end
        end
    endtask

    task automatic test_mid_reset();
        step_to(137);
        checks++;
        if (digit !== 4'b0100) begin failures++; $display("FAIL midreset_pre got=%b exp=0100", digit); end
        #2;
        rst = 1'b0;
        #1;                                        // no clock edge in between
        checks++;
        if (digit !== 4'b0001 || seg !== 8'h00 || fd !== 1'b0)
            begin failures++; $display("FAIL midreset_async got=%b/%h/%b exp=0001/00/0", digit, seg, fd); end
        checks++;
        if (seg_inv !== 8'hFF) begin failures++; $display("FAIL midreset_async_inv got=%h exp=FF", seg_inv); end
        step();
        step();
        rst = 1'b1;
        n = 0;
        step();
        checks++;
        if (digit !== 4'b0001 || seg !== 8'h3F)
            begin failures++; $display("FAIL midreset_restart got=%b/%h exp=0001/3F", digit, seg); end
        step_to(4);
        checks++;
        if (digit !== 4'b0001) begin failures++; $display("FAIL midreset_presc_zero got=%b exp=0001", digit); end
        step();
        checks++;
        if (digit !== 4'b0010) begin failures++; $display("FAIL midreset_second_digit got=%b exp=0010", digit); end
    endtask

    task automatic test_inversion();
        step_to(6);
        checks++;
        if (seg_inv !== 8'hC0) begin failures++; $display("FAIL inv_seg got=%h exp=C0", seg_inv); end
        checks++;
        if (digit_inv !== 4'b0010) begin failures++; $display("FAIL inv_digit got=%b exp=0010", digit_inv); end
        step_to(17);
        checks++;
        if (fd_inv !== 1'b1 || digit_inv !== 4'b0001)
            begin failures++; $display("FAIL inv_frame_done got=%b/%b exp=1/0001", fd_inv, digit_inv); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_deferred_load();
        test_load_at_boundary();
        test_dp_blank();
        test_mid_reset();
        test_inversion();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
